// File: rtl/srl_fifo_pkg.sv
// Shared constants and pointer-update encoding for the SRL16-backed FIFO read controller.
package srl_fifo_pkg;

  localparam int unsigned SRL_DEPTH = 16;
  localparam int unsigned PTR_W     = 4;
  localparam int unsigned LEVEL_W   = 5;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SRL_DEPTH - 1);

  // Pointer/flag update selector, encoded as {push, load}.
  typedef enum logic [1:0] {
    UpdIdle = 2'b00,
    UpdLoad = 2'b01,
    UpdPush = 2'b10,
    UpdBoth = 2'b11
  } upd_e;

  function automatic upd_e upd_sel(input logic push, input logic load);
    return upd_e'({push, load});
  endfunction

endpackage

// File: rtl/srl16_word.sv
// WIDTH-wide addressable shift register built from one SRL16E per bit; CE and address shared.
module srl16_word
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [PTR_W-1:0] A,
  output logic [WIDTH-1:0] Q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    srl16e u_srl (
      .CLK (CLK),
      .CE  (CE),
      .D   (D[g]),
      .A   (A),
      .Q   (Q[g])
    );
  end

endmodule

// File: rtl/srl16e.sv
// Behavioural model of a single-bit 16-deep SRL16E: shift on CE, asynchronous addressed read.
module srl16e (
  input  logic       CLK,
  input  logic       CE,
  input  logic       D,
  input  logic [3:0] A,
  output logic       Q
);

  logic [15:0] r_sr;

  always_ff @(posedge CLK) begin
    if (CE) begin
      r_sr <= {r_sr[14:0], D};
    end
  end

  assign Q = r_sr[A];

endmodule

// File: rtl/srl16_fifo_reader.sv
// Read-side controller for a 16-deep SRL FIFO with a registered output stage (17 words total).
module srl16_fifo_reader
  import srl_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [WIDTH-1:0]   IN_DATA,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [WIDTH-1:0]   OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [LEVEL_W-1:0] LEVEL
);

  logic [PTR_W-1:0]   r_ptr;
  logic               r_srl_empty;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [LEVEL_W-1:0] r_level;

  logic               w_srl_full;
  logic               w_push;
  logic               w_load;
  logic               w_pop;
  logic [WIDTH-1:0]   w_srl_q;
  upd_e               w_upd;

  // Readiness depends only on registered state, never on OUT_READY.
  assign w_srl_full = !r_srl_empty && (r_ptr == PTR_LAST);
  assign w_push     = IN_VALID && !w_srl_full;
  assign w_load     = !r_srl_empty && (!r_out_valid || OUT_READY);
  assign w_pop      = r_out_valid && OUT_READY;
  assign w_upd      = upd_sel(w_push, w_load);

  srl16_word #(
    .WIDTH (WIDTH)
  ) u_srl (
    .CLK (CLK),
    .CE  (w_push),
    .D   (IN_DATA),
    .A   (r_ptr),
    .Q   (w_srl_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ptr       <= '0;
      r_srl_empty <= 1'b1;
    end else begin
      unique case (w_upd)
        UpdIdle: ;
        UpdPush: begin
          if (r_srl_empty) begin
            r_srl_empty <= 1'b0;
          end else begin
            r_ptr <= r_ptr + PTR_W'(1);
          end
        end
        UpdLoad: begin
          if (r_ptr == '0) begin
            r_srl_empty <= 1'b1;
          end else begin
            r_ptr <= r_ptr - PTR_W'(1);
          end
        end
        // Shift and read cancel: the oldest word stays at the same address.
        UpdBoth: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_srl_q;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_level <= '0;
    end else if (w_push && !w_pop) begin
      r_level <= r_level + LEVEL_W'(1);
    end else if (!w_push && w_pop) begin
      r_level <= r_level - LEVEL_W'(1);
    end
  end

  assign IN_READY  = !w_srl_full;
  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign LEVEL     = r_level;

endmodule
